// File: rtl/display_sync_fsm.sv
// display_sync_fsm: raster timing generator built from nested horizontal/vertical FSMs
//   i_clk   - pixel clock, all state changes on the rising edge
//   rst_n   - asynchronous active-low reset, forces both FSMs to IDLE
//   o_vsync - frame sync, high for the VPULSE sync lines
//   o_hsync - line sync, high for HPULSE clocks at the start of every line
//   o_de    - data enable, high on active pixels of active lines only
//   DISP_SYNC_NEG_POL_EN - when defined, o_vsync/o_hsync are active low (reset value 1)
module display_sync_fsm #(
  parameter int VPULSE = 3,
  parameter int HPULSE = 3,
  parameter int VRES   = 240,
  parameter int HRES   = 320,
  parameter int VBP    = 3,
  parameter int VFP    = 5,
  parameter int HBP    = 3,
  parameter int HFP    = 5
) (
  input  logic i_clk,
  input  logic rst_n,
  output logic o_vsync,
  output logic o_hsync,
  output logic o_de
);
`ifdef DISP_SYNC_NEG_POL_EN
  localparam logic POL = 1'b1;
`else
  localparam logic POL = 1'b0;
`endif
  localparam int HMAX01 = HPULSE > HBP ? HPULSE : HBP;
  localparam int HMAX23 = HRES > HFP ? HRES : HFP;
  localparam int HMAX   = HMAX01 > HMAX23 ? HMAX01 : HMAX23;
  localparam int VMAX01 = VPULSE > VBP ? VPULSE : VBP;
  localparam int VMAX23 = VRES > VFP ? VRES : VFP;
  localparam int VMAX   = VMAX01 > VMAX23 ? VMAX01 : VMAX23;
  localparam int HW = $clog2(HMAX) + 1;
  localparam int VW = $clog2(VMAX) + 1;
  typedef enum logic [2:0] {H_IDLE, H_SYNC, H_BP, H_ACT, H_FP} hStateT;
  typedef enum logic [2:0] {V_IDLE, V_SYNC, V_BP, V_ACT, V_FP} vStateT;
  hStateT hState, hNext;
  vStateT vState, vNext;
  logic [HW-1:0] hCnt, hCntNext, hLen;
  logic [VW-1:0] vCnt, vCntNext, vLen;
  logic hLast, vLast, eol;
  logic hsyncNext, vsyncNext, deNext;
  always_ff @(posedge i_clk or negedge rst_n)
    if (!rst_n) begin
      hState  <= H_IDLE;
      vState  <= V_IDLE;
      hCnt    <= '0;
      vCnt    <= '0;
      o_hsync <= POL;
      o_vsync <= POL;
      o_de    <= 1'b0;
    end else begin
      hState  <= hNext;
      vState  <= vNext;
      hCnt    <= hCntNext;
      vCnt    <= vCntNext;
      o_hsync <= hsyncNext;
      o_vsync <= vsyncNext;
      o_de    <= deNext;
    end
  // Each counter restarts at zero on every segment change, so it only ever
  // spans the current segment; the vertical FSM steps once per line end.
  always_comb begin
    hLen = hState == H_SYNC ? HW'(HPULSE) : hState == H_BP ? HW'(HBP) :
           hState == H_ACT ? HW'(HRES) : HW'(HFP);
    hLast = hCnt == hLen - HW'(1);
    eol = hState == H_FP && hLast;
    hNext = hState == H_IDLE ? H_SYNC : !hLast ? hState : hState == H_SYNC ? H_BP :
            hState == H_BP ? H_ACT : hState == H_ACT ? H_FP : H_SYNC;
    hCntNext = (hState == H_IDLE || hLast) ? '0 : hCnt + HW'(1);
    vLen = vState == V_SYNC ? VW'(VPULSE) : vState == V_BP ? VW'(VBP) :
           vState == V_ACT ? VW'(VRES) : VW'(VFP);
    vLast = vCnt == vLen - VW'(1);
    vNext = vState == V_IDLE ? V_SYNC : !(eol && vLast) ? vState : vState == V_SYNC ? V_BP :
            vState == V_BP ? V_ACT : vState == V_ACT ? V_FP : V_SYNC;
    vCntNext = vState == V_IDLE ? '0 : !eol ? vCnt : vLast ? '0 : vCnt + VW'(1);
  end
  // Outputs decode the next state so the registered pins line up with the state itself.
  always_comb begin
    hsyncNext = (hNext == H_SYNC) ^ POL;
    vsyncNext = (vNext == V_SYNC) ^ POL;
    deNext = hNext == H_ACT && vNext == V_ACT;
  end
endmodule

// File: tb/tb_display_sync_fsm.sv
// tb_display_sync_fsm: scoreboard bench for display_sync_fsm on a reduced raster
module tb_display_sync_fsm;
  localparam int HPULSE = 3, HBP = 3, HRES = 20, HFP = 5;
  localparam int VPULSE = 3, VBP = 3, VRES = 10, VFP = 5;
  localparam int HTOT = HPULSE + HBP + HRES + HFP;
  localparam int VTOT = VPULSE + VBP + VRES + VFP;
  localparam int FRAME = HTOT * VTOT;
`ifdef DISP_SYNC_NEG_POL_EN
  localparam logic POL = 1'b1;
`else
  localparam logic POL = 1'b0;
`endif
  logic i_clk = 1'b0;
  logic rst_n = 1'b0;
  logic o_vsync, o_hsync, o_de;
  int checks = 0;
  int errors = 0;
  logic [2:0] expQ[$];
  int deCnt, deRise, vsHigh, hsRise, hs1, hs2, firstDe;
  logic prevDe, prevHs;
  display_sync_fsm #(
    .VPULSE(VPULSE), .HPULSE(HPULSE), .VRES(VRES), .HRES(HRES),
    .VBP(VBP), .VFP(VFP), .HBP(HBP), .HFP(HFP)
  ) dut (
    .i_clk(i_clk),
    .rst_n(rst_n),
    .o_vsync(o_vsync),
    .o_hsync(o_hsync),
    .o_de(o_de)
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [2:0] model(input int t);
    int x, y;
    logic de;
    x = t % HTOT;
    y = (t / HTOT) % VTOT;
    de = y >= VPULSE + VBP && y < VPULSE + VBP + VRES && x >= HPULSE + HBP && x < HPULSE + HBP + HRES;
    return {POL ^ (y < VPULSE), POL ^ (x < HPULSE), de};
  endfunction
  task automatic run(input int n);
    logic [2:0] e;
    deCnt = 0; deRise = 0; vsHigh = 0; hsRise = 0;
    hs1 = -1; hs2 = -1; firstDe = -1;
    prevDe = 1'b0; prevHs = 1'b0;
    for (int t = 0; t < n; t++) begin
      expQ.push_back(model(t));
      @(posedge i_clk);
      #1;
      e = expQ.pop_front();
      check($sformatf("pix t=%0d", t), {29'd0, o_vsync, o_hsync, o_de}, {29'd0, e});
      if (t < FRAME) begin
        deCnt += int'(o_de);
        if (o_de && !prevDe) begin
          deRise++;
          if (firstDe < 0) firstDe = t;
        end
        vsHigh += int'(o_vsync ^ POL);
        if ((o_hsync ^ POL) && !prevHs) begin
          hsRise++;
          if (hs1 < 0) hs1 = t;
          else if (hs2 < 0) hs2 = t;
        end
      end
      prevDe = o_de;
      prevHs = o_hsync ^ POL;
    end
  endtask
  initial begin
    repeat (3) @(negedge i_clk);
    check("rst_vsync", {31'd0, o_vsync}, {31'd0, POL});
    check("rst_hsync", {31'd0, o_hsync}, {31'd0, POL});
    check("rst_de", {31'd0, o_de}, 32'd0);
    rst_n = 1'b1;
    run(FRAME + (VPULSE + VBP + 2) * HTOT + HPULSE + HBP + 5);
    check("de_count", deCnt, VRES * HRES);
    check("de_pulses", deRise, VRES);
    check("vsync_high", vsHigh, VPULSE * HTOT);
    check("hsync_pulses", hsRise, VTOT);
    check("hsync_period", hs2 - hs1, HTOT);
    check("first_de", firstDe, (VPULSE + VBP) * HTOT + HPULSE + HBP);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_vsync", {31'd0, o_vsync}, {31'd0, POL});
    check("async_hsync", {31'd0, o_hsync}, {31'd0, POL});
    check("async_de", {31'd0, o_de}, 32'd0);
    repeat (2) @(negedge i_clk);
    check("hold_hsync", {31'd0, o_hsync}, {31'd0, POL});
    rst_n = 1'b1;
    run((VPULSE + 1) * HTOT);
    check("restart_vsync_high", vsHigh, VPULSE * HTOT);
    check("restart_hsync_pulses", hsRise, VPULSE + 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
